// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc - polyphonic voice allocator fed by a MIDI receiver.
//
// Takes the 3-byte message presented when busy_reading falls, decodes
// Note On / Note Off on one channel and keeps per-voice gate, note and
// velocity. A one-deep pending buffer absorbs a message that arrives while
// the previous one is still being allocated.
//
// Optional feature macro: MIDI_VOICE_STEAL_EN (when defined, a note-on with
// no matching and no free voice steals the oldest voice; otherwise it is
// dropped and counted).
//
// Ports:
//   clock         system clock
//   clr_n         asynchronous active-low reset
//   busy_reading  receiver busy flag (asynchronous, synchronised here)
//   midi_bytes    {status, data1 (note), data2 (velocity)}
//   voice_gate    per-voice sounding flag
//   voice_trig    per-voice one-cycle (re)start pulse
//   voice_note    7-bit note per voice, voice i at [7i+6:7i]
//   voice_vel     7-bit velocity per voice, voice i at [7i+6:7i]
//   drop_count    saturating count of lost messages
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0
) (
  input  logic                    clock,
  input  logic                    clr_n,
  input  logic                    busy_reading,
  input  logic [23:0]             midi_bytes,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [7:0]              drop_count
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [3:0] CH4 = 4'(CHANNEL);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_APPLY} state_t;
  typedef enum logic [1:0] {K_NONE, K_ON, K_OFF} kind_t;

  state_t state, state_nx;

  logic sync1, sync2, sync_d;
  logic evt, pop, ev_drop;

  logic        pend_valid;
  logic [7:0]  pend_status;
  logic [6:0]  pend_note, pend_vel;

  kind_t       w_kind, dec_kind;
  logic [6:0]  w_note, w_vel;

  logic [IW-1:0] scan_idx, match_idx, free_idx, old_idx, tgt_idx;
  logic          match_found, free_found;

  logic [NUM_VOICES-1:0] gate_r, trig_r;
  logic [6:0]            note_r [NUM_VOICES];
  logic [6:0]            vel_r  [NUM_VOICES];
  logic [IW-1:0]         age_r  [NUM_VOICES];

  logic apply_on, apply_off, tgt_ok, apply_drop;
  logic [8:0] drop_sum;

  // Only data bits [6:0] carry meaning; the MSBs of data bytes are ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, midi_bytes[15], midi_bytes[7]};

  assign evt     = sync_d & ~sync2;
  assign pop     = (state == S_LOAD);
  assign ev_drop = evt & pend_valid & ~pop;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= busy_reading;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  always_comb begin
    dec_kind = K_NONE;
    if (pend_status == {4'h9, CH4} && pend_vel != '0)
      dec_kind = K_ON;
    else if (pend_status == {4'h8, CH4} || pend_status == {4'h9, CH4})
      dec_kind = K_OFF;
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      // An event in IDLE is captured on the same edge, so LOAD can follow.
      S_IDLE:   if (pend_valid || evt) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_SEARCH;
      S_SEARCH: if (scan_idx == IW'(NUM_VOICES-1)) state_nx = S_APPLY;
      S_APPLY:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    apply_on   = (state == S_APPLY) && (w_kind == K_ON);
    apply_off  = (state == S_APPLY) && (w_kind == K_OFF);
    tgt_idx    = old_idx;
    tgt_ok     = 1'b0;
    apply_drop = 1'b0;
    if (match_found) begin
      tgt_idx = match_idx;
      tgt_ok  = 1'b1;
    end else if (free_found) begin
      tgt_idx = free_idx;
      tgt_ok  = 1'b1;
    end else begin
`ifdef MIDI_VOICE_STEAL_EN
      tgt_ok     = 1'b1;
`else
      apply_drop = apply_on;
`endif
    end
    drop_sum = {1'b0, drop_count} + 9'(ev_drop) + 9'(apply_drop);
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      pend_valid  <= 1'b0;
      pend_status <= '0;
      pend_note   <= '0;
      pend_vel    <= '0;
      w_kind      <= K_NONE;
      w_note      <= '0;
      w_vel       <= '0;
      scan_idx    <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      gate_r      <= '0;
      trig_r      <= '0;
      drop_count  <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
        age_r[i]  <= IW'(i);
      end
    end else begin
      // A pop frees the slot on the same edge, so a coincident event fits.
      if (evt && !ev_drop) begin
        pend_status <= midi_bytes[23:16];
        pend_note   <= midi_bytes[14:8];
        pend_vel    <= midi_bytes[6:0];
        pend_valid  <= 1'b1;
      end else if (pop) begin
        pend_valid  <= 1'b0;
      end

      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (pop) begin
        w_kind      <= dec_kind;
        w_note      <= pend_note;
        w_vel       <= pend_vel;
        scan_idx    <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
      end else if (state == S_SEARCH) begin
        if (gate_r[scan_idx] && note_r[scan_idx] == w_note && !match_found) begin
          match_found <= 1'b1;
          match_idx   <= scan_idx;
        end
        if (!gate_r[scan_idx] && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= scan_idx;
        end
        if (age_r[scan_idx] == IW'(NUM_VOICES-1)) old_idx <= scan_idx;
        scan_idx <= scan_idx + IW'(1);
      end

      trig_r <= '0;
      if (apply_on && tgt_ok) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (IW'(i) == tgt_idx)
            age_r[i] <= '0;
          else if (age_r[i] < age_r[tgt_idx])
            age_r[i] <= age_r[i] + IW'(1);
        end
        gate_r[tgt_idx] <= 1'b1;
        trig_r[tgt_idx] <= 1'b1;
        note_r[tgt_idx] <= w_note;
        vel_r[tgt_idx]  <= w_vel;
      end
      if (apply_off) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++)
          if (gate_r[i] && note_r[i] == w_note) gate_r[i] <= 1'b0;
      end
    end
  end

  assign voice_gate = gate_r;
  assign voice_trig = trig_r;

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_r[i];
      voice_vel[7*i +: 7]  = vel_r[i];
    end
  end

endmodule
